// File: rtl/reg_arb_pkg.sv
// Shared types, widths and helpers for the register-bank write arbiter.
package reg_arb_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_NREGS = 4;
  localparam int unsigned ADDR_W    = clog2(DEF_NREGS);
  localparam int unsigned IDX_W     = clog2(DEF_NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;
  int unsigned      s;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    off   = '0;
    s     = 0;
    // Rotate so that position 0 corresponds to ptr; modulo done by one conditional subtract.
    for (int unsigned k = 0; k < NREQ; k++) begin
      s = 32'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      rot[k] = eligible[IDX_W'(s)];
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    s = 32'(ptr) + 32'(off);
    if (s >= NREQ) s = s - NREQ;
    idx = IDX_W'(s);
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register bank write port, with capped locked bursts.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREQ      = DEF_NREQ,
  parameter int unsigned NREGS     = DEF_NREGS,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              lock,
  input  logic [NREQ*clog2(NREGS)-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [NREQ-1:0]              gnt,
  output logic [NREGS-1:0]             wr_en,
  output logic [WIDTH-1:0]             wr_data,
  output logic                         busy
);

  localparam int unsigned AW = clog2(NREGS);
  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned CW = clog2(MAX_BURST + 1);

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [IW-1:0]   cur, cur_d;
  logic [CW-1:0]   burst_cnt, burst_cnt_d;
  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IW-1:0]   pick;
  logic            held, forced;
  logic [NREQ-1:0] gnt_d;
  logic [NREGS-1:0] wr_en_d;
  logic [WIDTH-1:0] wr_data_d;
  logic [AW-1:0]   win_addr;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    eligible = req;
    if (state == GRANT) eligible[cur] = 1'b0;
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (found),
    .idx      (pick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      burst_cnt <= '0;
      gnt       <= '0;
      wr_en     <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cur       <= cur_d;
      burst_cnt <= burst_cnt_d;
      gnt       <= gnt_d;
      wr_en     <= wr_en_d;
      wr_data   <= wr_data_d;
    end
  end

  // Locked owner continues until the cap; at the cap it yields to any other eligible
  // requester, and only restarts a fresh burst when nobody else is waiting.
  always_comb begin
    held        = (state == GRANT) && req[cur] && lock[cur];
    forced      = held && (burst_cnt >= CW'(MAX_BURST));
    state_d     = IDLE;
    ptr_d       = ptr;
    cur_d       = cur;
    burst_cnt_d = '0;
    if (held && !forced) begin
      state_d     = GRANT;
      burst_cnt_d = burst_cnt + CW'(1);
    end else if (found) begin
      state_d     = GRANT;
      cur_d       = pick;
      ptr_d       = next_idx(pick);
      burst_cnt_d = CW'(1);
    end else if (forced) begin
      state_d     = GRANT;
      ptr_d       = next_idx(cur);
      burst_cnt_d = CW'(1);
    end
  end

  always_comb begin
    gnt_d     = '0;
    wr_en_d   = '0;
    wr_data_d = '0;
    win_addr  = '0;
    if (state_d == GRANT) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (cur_d == IW'(i)) begin
          gnt_d[i]  = 1'b1;
          win_addr  = req_addr[i*AW +: AW];
          wr_data_d = req_data[i*WIDTH +: WIDTH];
        end
      end
      // Out-of-range addresses match no register, so the grant goes out with no write enable.
      for (int unsigned r = 0; r < NREGS; r++) wr_en_d[r] = (win_addr == AW'(r));
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a cycle-level behavioural model.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int W  = 8;
  localparam int NQ = 4;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int AW = ADDR_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NQ-1:0]   req, lock;
  logic [NQ*AW-1:0] req_addr;
  logic [NQ*W-1:0] req_data;
  logic [NQ-1:0]   gnt;
  logic [NR-1:0]   wr_en;
  logic [W-1:0]    wr_data;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .WIDTH     (W),
    .NREQ      (NQ),
    .NREGS     (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [NQ-1:0] g, input logic [NR-1:0] we,
                     input logic [W-1:0] d, input logic b);
    chk({name, ".gnt"}, 32'(gnt), 32'(g));
    chk({name, ".wr_en"}, 32'(wr_en), 32'(we));
    chk({name, ".wr_data"}, 32'(wr_data), 32'(d));
    chk({name, ".busy"}, 32'(busy), 32'(b));
  endtask

  // Behavioural model: owner/ptr/burst as plain integers, -1 meaning no grant.
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_burst = 0;
  logic [NQ-1:0] e_gnt   = '0;
  logic [NR-1:0] e_wr_en = '0;
  logic [W-1:0]  e_data  = '0;

  task automatic model_step();
    int win;
    logic [AW-1:0] av;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_burst = 0;
      e_gnt = '0; e_wr_en = '0; e_data = '0;
      return;
    end
    win = -1;
    if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_burst < MB) begin
      win = m_owner;
      m_burst++;
    end else begin
      for (int k = 0; k < NQ; k++) begin
        int j;
        j = (m_ptr + k) % NQ;
        if (win < 0 && req[j] && j != m_owner) win = j;
      end
      if (win < 0 && m_owner >= 0 && req[m_owner] && lock[m_owner]) win = m_owner;
      if (win >= 0) begin
        m_ptr   = (win + 1) % NQ;
        m_burst = 1;
      end else begin
        m_burst = 0;
      end
    end
    m_owner = win;
    if (win < 0) begin
      e_gnt = '0; e_wr_en = '0; e_data = '0;
    end else begin
      e_gnt   = NQ'(1) << win;
      av      = AW'(req_addr >> (win * AW));
      e_wr_en = (int'(av) < NR) ? (NR'(1) << av) : '0;
      e_data  = W'(req_data >> (win * W));
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("cyc.gnt", 32'(gnt), 32'(e_gnt));
    chk("cyc.wr_en", 32'(wr_en), 32'(e_wr_en));
    chk("cyc.wr_data", 32'(wr_data), 32'(e_data));
    chk("cyc.busy", 32'(busy), 32'(e_gnt != '0));
    chk("cyc.gnt_pop", 32'($countones(gnt) <= 1), 32'd1);
    chk("cyc.wr_en_pop", 32'($countones(wr_en) <= 1), 32'd1);
    chk("cyc.data_idle", 32'((gnt == '0) && (wr_data != '0)), 32'd0);
  end

  logic [NQ-1:0] tab_req  [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b1001, 4'b0000};
  logic [NQ-1:0] tab_lock [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};

  initial begin
    rst_n    = 1'b0;
    req      = 4'b1111;
    lock     = 4'b0000;
    req_addr = 8'b00_01_10_11;
    req_data = 32'h44332211;
    @(negedge clk);
    @(negedge clk);
    lit("reset", 4'b0000, 4'b0000, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Round-robin with all requesting: requester w has addr 3-w and data 0x11*(w+1).
    for (int k = 0; k < 5; k++) begin
      int w;
      @(negedge clk);
      w = k % 4;
      lit("rr", NQ'(1) << w, NR'(1) << (3 - w), W'(8'h11 * (w + 1)), 1'b1);
    end
    req = 4'b0000;
    @(negedge clk);
    lit("rr_idle", 4'b0000, 4'b0000, 8'h00, 1'b0);

    req_addr[5:4]   = 2'd3;
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    lit("single", 4'b0100, 4'b1000, 8'hA5, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    lit("single_after", 4'b0000, 4'b0000, 8'h00, 1'b0);

    req = 4'b0001;
    @(negedge clk);
    lit("ptr_setup", 4'b0001, 4'b1000, 8'h11, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    lit("ptr_idle", 4'b0000, 4'b0000, 8'h00, 1'b0);

    req  = 4'b1010;
    lock = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lit("burst", 4'b0010, 4'b0100, 8'h22, 1'b1);
    end
    @(negedge clk);
    lit("burst_yield", 4'b1000, 4'b0001, 8'h44, 1'b1);
    @(negedge clk);
    lit("burst_new", 4'b0010, 4'b0100, 8'h22, 1'b1);

    req = 4'b0010;
    for (int k = 0; k < 4; k++) @(negedge clk);
    lit("cap_regrant", 4'b0010, 4'b0100, 8'h22, 1'b1);
    req  = 4'b0000;
    lock = 4'b0000;
    @(negedge clk);
    lit("cap_idle", 4'b0000, 4'b0000, 8'h00, 1'b0);

    req = 4'b0001;
    @(negedge clk);
    lit("b2b0", 4'b0001, 4'b1000, 8'h11, 1'b1);
    req = 4'b0010;
    @(negedge clk);
    lit("b2b1", 4'b0010, 4'b0100, 8'h22, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    lit("b2b_idle", 4'b0000, 4'b0000, 8'h00, 1'b0);

    req  = 4'b0010;
    lock = 4'b0010;
    @(negedge clk);
    lit("rstb1", 4'b0010, 4'b0100, 8'h22, 1'b1);
    @(negedge clk);
    lit("rstb2", 4'b0010, 4'b0100, 8'h22, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    lit("rst_mid", 4'b0000, 4'b0000, 8'h00, 1'b0);
    rst_n = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    @(negedge clk);
    lit("rst_restart", 4'b0001, 4'b1000, 8'h11, 1'b1);

    req_addr = 8'b11_10_01_00;
    for (int k = 0; k < 8; k++) begin
      req  = tab_req[k];
      lock = tab_lock[k];
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
